// File: rtl/fifo_wr_arbiter_if.sv
// Bundle between the write arbiter, its requesters and the FIFO write port.
// The slave modport is the arbiter; the master modport is the surrounding environment.
interface fifo_wr_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int W_CNT = 2,
    parameter int REQS  = 4
);
    logic [REQS-1:0][W_CNT-1:0]             req_e;
    logic [REQS-1:0][W_CNT-1:0][WIDTH-1:0]  req_data;
    logic [REQS-1:0]                        req_ready;
    logic [W_CNT-1:0]                       w_e;
    logic [W_CNT-1:0][WIDTH-1:0]            w_data;
    logic [W_CNT-1:0]                       w_ack;

    modport master (
        output req_e, req_data, w_ack,
        input  req_ready, w_e, w_data
    );

    modport slave (
        input  req_e, req_data, w_ack,
        output req_ready, w_e, w_data
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that stages one requester packet at a time and drives it into
// the multi-slot FIFO write port, retiring entries as the FIFO acks them.
module fifo_wr_arbiter #(
    parameter int WIDTH = 32,
    parameter int W_CNT = 2,
    parameter int REQS  = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    fifo_wr_arbiter_if.slave        io_bus,
    input  logic                    i_flush,
    output logic                    o_busy,
    output logic [$clog2(REQS)-1:0] o_grant_id
);
    localparam int IDW = $clog2(REQS);
    localparam int CW  = $clog2(W_CNT + 1);

    typedef enum logic {S_IDLE = 1'b0, S_ISSUE = 1'b1} state_t;

    state_t                      r_state, w_state_next;
    logic [W_CNT-1:0]            r_stg_e, w_stg_e_next;
    logic [W_CNT-1:0][WIDTH-1:0] r_stg_data, w_stg_data_next;
    logic [IDW-1:0]              r_rr_ptr, w_rr_ptr_next;
    logic [IDW-1:0]              r_grant_id, w_grant_id_next;

    logic [REQS-1:0][W_CNT-1:0]  w_req_eff;
    logic                        w_found;
    logic [IDW-1:0]              w_gnt;
    logic                        w_grant_fire;
    logic [CW-1:0]               w_ack_cnt;
    logic [W_CNT-1:0]            w_shift_e;
    logic [W_CNT-1:0][WIDTH-1:0] w_shift_data;
    logic                        w_retire;

    // Effective entries are the leading ones of each requester's bitmap.
    for (genvar gi = 0; gi < REQS; gi++) begin : g_eff
        logic [W_CNT-1:0] w_eff;
        always_comb begin
            logic v_run;
            v_run = 1'b1;
            w_eff = '0;
            for (int s = 0; s < W_CNT; s++) begin
                v_run    = v_run & io_bus.req_e[gi][s];
                w_eff[s] = v_run;
            end
        end
        assign w_req_eff[gi] = w_eff;
    end

    // Lowest offset from rr_ptr wins, so scan offsets from the far end down.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        for (int off = REQS - 1; off >= 0; off--) begin
            logic [IDW-1:0] v_idx;
            v_idx = r_rr_ptr + IDW'(off);
            if (io_bus.req_e[v_idx][0]) begin
                w_found = 1'b1;
                w_gnt   = v_idx;
            end
        end
    end

    // Only the leading acked run retires; a gap or out-of-range ack bit stops the count.
    always_comb begin
        logic v_run;
        v_run     = 1'b1;
        w_ack_cnt = '0;
        for (int s = 0; s < W_CNT; s++) begin
            v_run = v_run & io_bus.w_ack[s] & r_stg_e[s];
            if (v_run) begin
                w_ack_cnt = w_ack_cnt + CW'(1);
            end
        end
    end

    always_comb begin
        w_shift_e = r_stg_e >> w_ack_cnt;
        for (int s = 0; s < W_CNT; s++) begin
            w_shift_data[s] = '0;
            for (int k = 0; s + k < W_CNT; k++) begin
                if (int'(w_ack_cnt) == k) begin
                    w_shift_data[s] = r_stg_data[s + k];
                end
            end
        end
    end

    assign w_retire = (r_state == S_ISSUE) && (w_shift_e == '0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_stg_e    <= '0;
            r_stg_data <= '0;
            r_rr_ptr   <= '0;
            r_grant_id <= '0;
        end else begin
            r_state    <= w_state_next;
            r_stg_e    <= w_stg_e_next;
            r_stg_data <= w_stg_data_next;
            r_rr_ptr   <= w_rr_ptr_next;
            r_grant_id <= w_grant_id_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_stg_e_next    = r_stg_e;
        w_stg_data_next = r_stg_data;
        w_rr_ptr_next   = r_rr_ptr;
        w_grant_id_next = r_grant_id;
        w_grant_fire    = 1'b0;
        if (i_flush) begin
            w_state_next    = S_IDLE;
            w_stg_e_next    = '0;
            w_stg_data_next = '0;
        end else begin
            if (r_state == S_ISSUE && !w_retire) begin
                w_stg_e_next    = w_shift_e;
                w_stg_data_next = w_shift_data;
            end
            // A retiring packet hands the staging register straight to the next winner.
            if ((r_state == S_IDLE || w_retire) && w_found) begin
                w_grant_fire    = 1'b1;
                w_state_next    = S_ISSUE;
                w_stg_e_next    = w_req_eff[w_gnt];
                w_stg_data_next = io_bus.req_data[w_gnt];
                w_rr_ptr_next   = w_gnt + IDW'(1);
                w_grant_id_next = w_gnt;
            end else if (w_retire) begin
                w_state_next    = S_IDLE;
                w_stg_e_next    = '0;
                w_stg_data_next = '0;
            end
        end
    end

    always_comb begin
        io_bus.w_e       = '0;
        io_bus.w_data    = '0;
        io_bus.req_ready = '0;
        if (r_state == S_ISSUE) begin
            io_bus.w_e    = r_stg_e;
            io_bus.w_data = r_stg_data;
        end
        if (w_grant_fire && !i_rst) begin
            io_bus.req_ready = REQS'(1) << w_gnt;
        end
    end

    assign o_busy     = (r_state == S_ISSUE);
    assign o_grant_id = r_grant_id;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: scenario tasks push expected grants and FIFO
// presentations, a negedge monitor pops and compares them as the DUT produces them.
module tb_fifo_wr_arbiter;
    localparam int WIDTH = 32;
    localparam int W_CNT = 2;
    localparam int REQS  = 4;

    typedef logic [W_CNT-1:0][WIDTH-1:0] slots_t;
    typedef struct packed {
        logic [W_CNT-1:0] e;
        slots_t           data;
        logic [1:0]       gid;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       busy;
    logic [1:0] gid;

    int  checks   = 0;
    int  failures = 0;
    bit  mon_en   = 1'b0;
    wr_t exp_wr_q[$];
    int  exp_gnt_q[$];
    int  mon_g;
    wr_t mon_w;

    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.WIDTH(WIDTH), .W_CNT(W_CNT), .REQS(REQS)) bus_if ();

    fifo_wr_arbiter #(.WIDTH(WIDTH), .W_CNT(W_CNT), .REQS(REQS)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .io_bus     (bus_if),
        .i_flush    (flush),
        .o_busy     (busy),
        .o_grant_id (gid)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_wr(input logic [W_CNT-1:0] e, input logic [WIDTH-1:0] d1,
                           input logic [WIDTH-1:0] d0, input int g);
        wr_t w;
        w.e       = e;
        w.data[1] = d1;
        w.data[0] = d0;
        w.gid     = 2'(g);
        exp_wr_q.push_back(w);
    endtask

    function automatic logic [WIDTH-1:0] pd(input int r, input int n, input int s);
        return 32'h3000_0000 | 32'(r << 8) | 32'(n << 4) | 32'(s);
    endfunction

    // Monitor: every ready pulse and every FIFO presentation must match the next queued expectation.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus_if.req_ready !== '0) begin
                checks++;
                if (exp_gnt_q.size() == 0) begin
                    failures++;
                    $display("FAIL ready_unexpected got=%b required=none", bus_if.req_ready);
                end else begin
                    mon_g = exp_gnt_q.pop_front();
                    $display("grant ready=%b expect_req=%0d", bus_if.req_ready, mon_g);
                    if (bus_if.req_ready !== (REQS'(1) << mon_g)) begin
                        failures++;
                        $display("FAIL ready_onehot got=%b required_req=%0d", bus_if.req_ready, mon_g);
                    end
                end
            end
            if (bus_if.w_e !== '0) begin
                checks++;
                if (exp_wr_q.size() == 0) begin
                    failures++;
                    $display("FAIL write_unexpected got_w_e=%b", bus_if.w_e);
                end else begin
                    mon_w = exp_wr_q.pop_front();
                    $display("write w_e=%b d1=%h d0=%h gid=%0d", bus_if.w_e, bus_if.w_data[1],
                             bus_if.w_data[0], gid);
                    if (bus_if.w_e !== mon_w.e || gid !== mon_w.gid ||
                        (mon_w.e[0] && bus_if.w_data[0] !== mon_w.data[0]) ||
                        (mon_w.e[1] && bus_if.w_data[1] !== mon_w.data[1])) begin
                        failures++;
                        $display("FAIL write_pkt got w_e=%b gid=%0d d1=%h d0=%h required w_e=%b gid=%0d d1=%h d0=%h",
                                 bus_if.w_e, gid, bus_if.w_data[1], bus_if.w_data[0],
                                 mon_w.e, mon_w.gid, mon_w.data[1], mon_w.data[0]);
                    end
                end
            end
        end
    end

    task automatic drain_check(input string name);
        checks++;
        if (exp_wr_q.size() != 0 || exp_gnt_q.size() != 0) begin
            failures++;
            $display("FAIL %s_drain got_pending_wr=%0d pending_gnt=%0d required=0", name,
                     exp_wr_q.size(), exp_gnt_q.size());
        end
        exp_wr_q.delete();
        exp_gnt_q.delete();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus_if.req_e[1] = 2'b11;
        tick();
        tick();
        mon_en = 1'b1;
        @(negedge clk);
        checks++;
        if (bus_if.w_e !== '0 || bus_if.w_data !== '0) begin
            failures++;
            $display("FAIL reset_w got w_e=%b required=0", bus_if.w_e);
        end
        checks++;
        if (busy !== 1'b0 || gid !== 2'd0) begin
            failures++;
            $display("FAIL reset_state got busy=%b gid=%0d required busy=0 gid=0", busy, gid);
        end
        checks++;
        if (bus_if.req_ready !== '0) begin
            failures++;
            $display("FAIL reset_ready got=%b required=0", bus_if.req_ready);
        end
        tick();
        rst = 1'b0;
        bus_if.req_e = '0;
    endtask

    task automatic test_single_full_ack;
        exp_gnt_q.push_back(1);
        push_wr(2'b11, 32'hBBBB_0002, 32'hAAAA_0001, 1);
        bus_if.req_e[1]       = 2'b11;
        bus_if.req_data[1][0] = 32'hAAAA_0001;
        bus_if.req_data[1][1] = 32'hBBBB_0002;
        bus_if.w_ack          = 2'b11;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || bus_if.req_ready !== 4'b0010) begin
            failures++;
            $display("FAIL t1_c0 got busy=%b ready=%b required busy=0 ready=0010", busy, bus_if.req_ready);
        end
        tick();
        bus_if.req_e[1] = 2'b00;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL t1_busy_c1 got=%b required=1", busy);
        end
        tick();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || gid !== 2'd1) begin
            failures++;
            $display("FAIL t1_c2 got busy=%b gid=%0d required busy=0 gid=1", busy, gid);
        end
        tick();
        drain_check("t1");
    endtask

    task automatic test_partial_ack;
        exp_gnt_q.push_back(0);
        push_wr(2'b11, 32'hBBBB_0012, 32'hAAAA_0011, 0);
        push_wr(2'b01, 32'h0, 32'hBBBB_0012, 0);
        bus_if.req_e[0]       = 2'b11;
        bus_if.req_data[0][0] = 32'hAAAA_0011;
        bus_if.req_data[0][1] = 32'hBBBB_0012;
        bus_if.w_ack          = 2'b01;
        @(negedge clk);
        tick();
        bus_if.req_e[0] = 2'b00;
        @(negedge clk);
        tick();
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || bus_if.w_e !== 2'b01) begin
            failures++;
            $display("FAIL t2_c2 got busy=%b w_e=%b required busy=1 w_e=01", busy, bus_if.w_e);
        end
        tick();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL t2_busy_c3 got=%b required=0", busy);
        end
        tick();
        drain_check("t2");
    endtask

    task automatic test_back_to_back;
        int n[REQS];
        int g;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int r = 0; r < REQS; r++) n[r] = 0;
        for (int k = 0; k < 5; k++) begin
            g = k % REQS;
            exp_gnt_q.push_back(g);
            push_wr(2'b11, pd(g, n[g], 1), pd(g, n[g], 0), g);
            n[g]++;
        end
        for (int r = 0; r < REQS; r++) begin
            n[r] = 0;
            bus_if.req_e[r]       = 2'b11;
            bus_if.req_data[r][0] = pd(r, 0, 0);
            bus_if.req_data[r][1] = pd(r, 0, 1);
        end
        bus_if.w_ack = 2'b11;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (bus_if.req_ready !== (4'b0001 << (k % REQS)) || busy !== (k > 0)) begin
                failures++;
                $display("FAIL t3_grant_%0d got ready=%b busy=%b required_req=%0d", k,
                         bus_if.req_ready, busy, k % REQS);
            end
            tick();
            g = k % REQS;
            n[g]++;
            bus_if.req_data[g][0] = pd(g, n[g], 0);
            bus_if.req_data[g][1] = pd(g, n[g], 1);
            if (k == 4) bus_if.req_e = '0;
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL t3_last_issue got busy=%b required=1", busy);
        end
        tick();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL t3_idle got busy=%b required=0", busy);
        end
        tick();
        drain_check("t3");
    endtask

    task automatic test_stall;
        exp_gnt_q.push_back(2);
        for (int i = 0; i < 6; i++) push_wr(2'b01, 32'h0, 32'hCCCC_0003, 2);
        bus_if.req_e[2]       = 2'b01;
        bus_if.req_data[2][0] = 32'hCCCC_0003;
        bus_if.req_data[2][1] = 32'hDEAD_0000;
        bus_if.w_ack          = 2'b00;
        @(negedge clk);
        tick();
        bus_if.req_e[2] = 2'b00;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b1 || bus_if.req_ready !== '0) begin
                failures++;
                $display("FAIL t4_stall_%0d got busy=%b ready=%b required busy=1 ready=0", i, busy,
                         bus_if.req_ready);
            end
            tick();
        end
        bus_if.w_ack = 2'b01;
        @(negedge clk);
        tick();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL t4_retire got busy=%b required=0", busy);
        end
        tick();
        drain_check("t4");
    endtask

    task automatic test_flush;
        exp_gnt_q.push_back(3);
        push_wr(2'b11, 32'hEEEE_0005, 32'hDDDD_0004, 3);
        push_wr(2'b01, 32'h0, 32'hEEEE_0005, 3);
        exp_gnt_q.push_back(0);
        push_wr(2'b11, 32'h6666_0007, 32'hFFFF_0006, 0);
        exp_gnt_q.push_back(3);
        push_wr(2'b01, 32'h0, 32'h8888_0008, 3);
        bus_if.req_e[3]       = 2'b11;
        bus_if.req_data[3][0] = 32'hDDDD_0004;
        bus_if.req_data[3][1] = 32'hEEEE_0005;
        bus_if.w_ack          = 2'b01;
        @(negedge clk);
        tick();
        bus_if.req_e[3] = 2'b00;
        @(negedge clk);
        tick();
        flush                 = 1'b1;
        bus_if.w_ack          = 2'b00;
        bus_if.req_e[0]       = 2'b11;
        bus_if.req_data[0][0] = 32'hFFFF_0006;
        bus_if.req_data[0][1] = 32'h6666_0007;
        bus_if.req_e[3]       = 2'b01;
        bus_if.req_data[3][0] = 32'h8888_0008;
        @(negedge clk);
        checks++;
        if (bus_if.req_ready !== '0) begin
            failures++;
            $display("FAIL t5_flush_ready got=%b required=0", bus_if.req_ready);
        end
        tick();
        flush = 1'b0;
        @(negedge clk);
        checks++;
        if (bus_if.w_e !== '0 || busy !== 1'b0 || bus_if.req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL t5_after_flush got w_e=%b busy=%b ready=%b required w_e=0 busy=0 ready=0001",
                     bus_if.w_e, busy, bus_if.req_ready);
        end
        tick();
        bus_if.req_e[0] = 2'b00;
        bus_if.w_ack    = 2'b11;
        @(negedge clk);
        checks++;
        if (bus_if.req_ready !== 4'b1000) begin
            failures++;
            $display("FAIL t5_next_grant got=%b required=1000", bus_if.req_ready);
        end
        tick();
        bus_if.req_e[3] = 2'b00;
        @(negedge clk);
        tick();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL t5_idle got busy=%b required=0", busy);
        end
        tick();
        drain_check("t5");
    endtask

    task automatic test_bad_req_and_reset;
        bus_if.req_e[1] = 2'b10;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus_if.req_ready !== '0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL t6_bad_req_%0d got ready=%b busy=%b required 0 0", i, bus_if.req_ready, busy);
            end
            tick();
        end
        bus_if.req_e[1] = 2'b00;
        exp_gnt_q.push_back(2);
        push_wr(2'b11, 32'h1111_000A, 32'h9999_0009, 2);
        bus_if.req_e[2]       = 2'b11;
        bus_if.req_data[2][0] = 32'h9999_0009;
        bus_if.req_data[2][1] = 32'h1111_000A;
        bus_if.w_ack          = 2'b00;
        @(negedge clk);
        tick();
        bus_if.req_e[2] = 2'b00;
        rst             = 1'b1;
        @(negedge clk);
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus_if.w_e !== '0 || bus_if.w_data !== '0 || busy !== 1'b0 || gid !== 2'd0 ||
            bus_if.req_ready !== '0) begin
            failures++;
            $display("FAIL t6_after_reset got w_e=%b busy=%b gid=%0d ready=%b required all zero",
                     bus_if.w_e, busy, gid, bus_if.req_ready);
        end
        tick();
        exp_gnt_q.push_back(0);
        push_wr(2'b01, 32'h0, 32'h2222_000B, 0);
        exp_gnt_q.push_back(3);
        push_wr(2'b01, 32'h0, 32'h3333_000C, 3);
        bus_if.req_e[0]       = 2'b01;
        bus_if.req_data[0][0] = 32'h2222_000B;
        bus_if.req_e[3]       = 2'b01;
        bus_if.req_data[3][0] = 32'h3333_000C;
        bus_if.w_ack          = 2'b01;
        @(negedge clk);
        checks++;
        if (bus_if.req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL t6_first_grant got=%b required=0001", bus_if.req_ready);
        end
        tick();
        bus_if.req_e[0] = 2'b00;
        @(negedge clk);
        tick();
        bus_if.req_e[3] = 2'b00;
        @(negedge clk);
        tick();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL t6_idle got busy=%b required=0", busy);
        end
        tick();
        drain_check("t6");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst             = 1'b1;
        flush           = 1'b0;
        bus_if.req_e    = '0;
        bus_if.req_data = '0;
        bus_if.w_ack    = '0;
        test_reset();
        test_single_full_ack();
        test_partial_ack();
        test_back_to_back();
        test_stall();
        test_flush();
        test_bad_req_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
